// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard scoreboard: default field width, stage indices
// and the scoreboard entry type.
package hazard_pkg;

    localparam int TW_DEF = 2;

    // Entry fields are sized for the widest supported configuration; narrower
    // register/latency fields are zero-extended into them.
    localparam int AW_MAX = 8;
    localparam int TW_MAX = 4;

    localparam int STG_E = 0;
    localparam int STG_M = 1;
    localparam int STG_W = 2;
    localparam int NSTG  = 3;

    typedef struct packed {
        logic              we;
        logic [AW_MAX-1:0] dst;
        logic [TW_MAX-1:0] tnew;
    } sb_entry_t;

    function automatic sb_entry_t sb_advance(input sb_entry_t ent);
        sb_entry_t nxt;
        nxt = ent;
        if (ent.tnew != '0) begin
            nxt.tnew = ent.tnew - TW_MAX'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hazard_fwd_mux.sv
// Priority match-and-select of one operand against the E/M/W scoreboard entries.
// The youngest enabled matching producer wins; its Tnew is reported for stall decisions.
module hazard_fwd_mux import hazard_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [AW_MAX-1:0] src,
    input  sb_entry_t         ent [NSTG],
    input  logic [NSTG-1:0]   en,
    input  logic [DATA_W-1:0] wd [NSTG],
    input  logic [DATA_W-1:0] raw,
    output logic [DATA_W-1:0] fwd,
    output logic [TW_MAX-1:0] win_tnew
);

    // Walk oldest to youngest so a younger match overrides an older one.
    always_comb begin
        fwd      = raw;
        win_tnew = '0;
        for (int i = NSTG - 1; i >= 0; i--) begin
            if (en[i] && ent[i].we && (ent[i].dst == src) && (src != '0)) begin
                win_tnew = ent[i].tnew;
                fwd      = (ent[i].tnew == '0) ? wd[i] : raw;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Tnew/Tuse hazard scoreboard with D/E/M operand bypassing and D-stage stall.
// Define HAZARD_MD_EN to compile in the mult/div busy counter and its stall term.
module hazard_scoreboard import hazard_pkg::*; #(
    parameter int DATA_W   = 32,
    parameter int AW       = 5,
    parameter int NSRC     = 2,
    parameter int TW       = TW_DEF,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   d_valid,
    input  logic [NSRC*AW-1:0]     d_src,
    input  logic [NSRC*TW-1:0]     d_tuse,
    input  logic [AW-1:0]          d_dst,
    input  logic                   d_we,
    input  logic [TW-1:0]          d_tnew,
    input  logic                   d_md_start,
    input  logic                   d_md_div,
    input  logic                   d_md_use,
    input  logic [NSRC*DATA_W-1:0] d_rd,
    input  logic [NSRC*DATA_W-1:0] e_op,
    input  logic [NSRC*DATA_W-1:0] m_op,
    input  logic [DATA_W-1:0]      e_wd,
    input  logic [DATA_W-1:0]      m_wd,
    input  logic [DATA_W-1:0]      w_wd,
    output logic                   stall,
    output logic [NSRC*DATA_W-1:0] d_fwd,
    output logic [NSRC*DATA_W-1:0] e_fwd,
    output logic [NSRC*DATA_W-1:0] m_fwd,
    output logic                   md_busy
);

    sb_entry_t         sb [NSTG];
    sb_entry_t         d_entry;
    logic [AW-1:0]     e_src [NSRC];
    logic [AW-1:0]     m_src [NSRC];
    logic [DATA_W-1:0] stage_wd [NSTG];
    logic [TW_MAX-1:0] d_win_tnew [NSRC];
    logic              data_hazard;
    logic              md_stall;
    logic              accept;

    assign stage_wd[STG_E] = e_wd;
    assign stage_wd[STG_M] = m_wd;
    assign stage_wd[STG_W] = w_wd;

    always_comb begin
        d_entry               = '0;
        d_entry.we            = d_we;
        d_entry.dst[AW-1:0]   = d_dst;
        d_entry.tnew[TW-1:0]  = d_tnew;
    end

    // D compares against all three entries, E against M/W, M against W only.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [TW_MAX-1:0] unused_e_tnew;
        logic [TW_MAX-1:0] unused_m_tnew;

        hazard_fwd_mux #(.DATA_W(DATA_W)) u_d_mux (
            .src      (AW_MAX'(d_src[i*AW +: AW])),
            .ent      (sb),
            .en       (3'b111),
            .wd       (stage_wd),
            .raw      (d_rd[i*DATA_W +: DATA_W]),
            .fwd      (d_fwd[i*DATA_W +: DATA_W]),
            .win_tnew (d_win_tnew[i])
        );

        hazard_fwd_mux #(.DATA_W(DATA_W)) u_e_mux (
            .src      (AW_MAX'(e_src[i])),
            .ent      (sb),
            .en       (3'b110),
            .wd       (stage_wd),
            .raw      (e_op[i*DATA_W +: DATA_W]),
            .fwd      (e_fwd[i*DATA_W +: DATA_W]),
            .win_tnew (unused_e_tnew)
        );

        hazard_fwd_mux #(.DATA_W(DATA_W)) u_m_mux (
            .src      (AW_MAX'(m_src[i])),
            .ent      (sb),
            .en       (3'b100),
            .wd       (stage_wd),
            .raw      (m_op[i*DATA_W +: DATA_W]),
            .fwd      (m_fwd[i*DATA_W +: DATA_W]),
            .win_tnew (unused_m_tnew)
        );
    end

    always_comb begin
        data_hazard = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (d_win_tnew[i] > TW_MAX'(d_tuse[i*TW +: TW])) begin
                data_hazard = 1'b1;
            end
        end
    end

    assign stall  = (d_valid && data_hazard) || md_stall;
    assign accept = d_valid && !stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NSTG; s++) begin
                sb[s] <= '0;
            end
            for (int i = 0; i < NSRC; i++) begin
                e_src[i] <= '0;
                m_src[i] <= '0;
            end
        end else begin
            sb[STG_W] <= sb_advance(sb[STG_M]);
            sb[STG_M] <= sb_advance(sb[STG_E]);
            sb[STG_E] <= accept ? d_entry : '0;
            for (int i = 0; i < NSRC; i++) begin
                m_src[i] <= e_src[i];
                e_src[i] <= accept ? d_src[i*AW +: AW] : '0;
            end
        end
    end

`ifdef HAZARD_MD_EN
    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] md_count;
    logic          e_md_start;
    logic          e_md_div;

    // The unit starts counting as the op leaves E; the E-stage flag covers the gap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_count   <= '0;
            e_md_start <= 1'b0;
            e_md_div   <= 1'b0;
        end else begin
            e_md_start <= accept && d_md_start;
            e_md_div   <= accept && d_md_div;
            if (e_md_start) begin
                md_count <= e_md_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
            end else if (md_count != '0) begin
                md_count <= md_count - CW'(1);
            end
        end
    end

    assign md_busy  = (md_count != '0);
    assign md_stall = d_valid && d_md_use && (md_busy || e_md_start);
`else
    localparam int unused_md_lat = MULT_LAT + DIV_LAT;
    logic unused_md;

    assign unused_md = ^{d_md_start, d_md_div, d_md_use};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard: expected outputs are queued as
// stimulus is driven and popped against the DUT on the following falling edge.
module tb_hazard_scoreboard;

    localparam int DATA_W = 32;
    localparam int AW     = 5;
    localparam int NSRC   = 2;
    localparam int TW     = 2;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   d_valid;
    logic [NSRC*AW-1:0]     d_src;
    logic [NSRC*TW-1:0]     d_tuse;
    logic [AW-1:0]          d_dst;
    logic                   d_we;
    logic [TW-1:0]          d_tnew;
    logic                   d_md_start, d_md_div, d_md_use;
    logic [NSRC*DATA_W-1:0] d_rd, e_op, m_op;
    logic [DATA_W-1:0]      e_wd, m_wd, w_wd;
    logic                   stall;
    logic [NSRC*DATA_W-1:0] d_fwd, e_fwd, m_fwd;
    logic                   md_busy;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .DATA_W(DATA_W), .AW(AW), .NSRC(NSRC), .TW(TW), .MULT_LAT(5), .DIV_LAT(10)
    ) dut (
        .clk(clk), .reset(reset), .d_valid(d_valid), .d_src(d_src), .d_tuse(d_tuse),
        .d_dst(d_dst), .d_we(d_we), .d_tnew(d_tnew), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_use(d_md_use), .d_rd(d_rd), .e_op(e_op), .m_op(m_op),
        .e_wd(e_wd), .m_wd(m_wd), .w_wd(w_wd), .stall(stall), .d_fwd(d_fwd),
        .e_fwd(e_fwd), .m_fwd(m_fwd), .md_busy(md_busy)
    );

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic logic [31:0] observe(string name);
        if (name == "stall")   return {31'b0, stall};
        if (name == "md_busy") return {31'b0, md_busy};
        if (name == "d_fwd0")  return d_fwd[31:0];
        if (name == "d_fwd1")  return d_fwd[63:32];
        if (name == "e_fwd0")  return e_fwd[31:0];
        if (name == "e_fwd1")  return e_fwd[63:32];
        if (name == "m_fwd0")  return m_fwd[31:0];
        if (name == "m_fwd1")  return m_fwd[63:32];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic push_exp(string name, logic [31:0] val);
        exp_t e;
        e.name = name;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drive_idle();
        d_valid = 1'b0; d_we = 1'b0; d_dst = '0; d_tnew = '0;
        d_src = '0; d_tuse = '1;
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
    endtask

    task automatic issue(logic [AW-1:0] dst, logic we, logic [TW-1:0] tnew);
        drive_idle();
        d_valid = 1'b1; d_we = we; d_dst = dst; d_tnew = tnew;
    endtask

    task automatic consume(logic [AW-1:0] src0, logic [TW-1:0] tuse0);
        drive_idle();
        d_valid = 1'b1; d_src = {5'd0, src0}; d_tuse = {2'd3, tuse0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        drive_idle();
        repeat (4) next_cycle();
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 4; cyc++) begin
            d_valid = 1'b1; d_we = 1'b1;
            d_src = 10'($urandom); d_tuse = 4'($urandom); d_dst = 5'($urandom);
            d_tnew = 2'($urandom); d_md_start = 1'b1; d_md_use = 1'b1; d_md_div = 1'($urandom);
            d_rd = {$urandom, $urandom}; e_op = {$urandom, $urandom}; m_op = {$urandom, $urandom};
            e_wd = $urandom; m_wd = $urandom; w_wd = $urandom;
            push_exp("stall", 0);
            push_exp("md_busy", 0);
            push_exp("d_fwd0", d_rd[31:0]);
            push_exp("d_fwd1", d_rd[63:32]);
            push_exp("e_fwd0", e_op[31:0]);
            push_exp("m_fwd1", m_op[63:32]);
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL reset %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_alu_chain();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 4; cyc++) begin
            case (cyc)
                0: begin issue(5'd8, 1'b1, 2'd0); push_exp("stall", 0); end
                1: begin
                    consume(5'd8, 2'd1);
                    e_wd = 32'h1234; d_rd = {32'h5555_0001, 32'hDEAD_0000};
                    push_exp("stall", 0);
                    push_exp("d_fwd0", 32'h1234);
                    push_exp("d_fwd1", 32'h5555_0001);
                end
                2: begin
                    drive_idle();
                    m_wd = 32'hAAAA_0001; e_op = {32'h7777_0000, 32'h1111};
                    push_exp("e_fwd0", 32'hAAAA_0001);
                    push_exp("e_fwd1", 32'h7777_0000);
                end
                default: begin
                    w_wd = 32'hBBBB_0002; m_op = {32'h0, 32'h2222};
                    push_exp("m_fwd0", 32'hBBBB_0002);
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL alu_chain %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 4; cyc++) begin
            case (cyc)
                0: begin issue(5'd9, 1'b1, 2'd2); push_exp("stall", 0); end
                1, 2: begin
                    consume(5'd9, 2'd1);
                    d_rd = {32'h0, 32'h0BAD};
                    push_exp("stall", (cyc == 1) ? 32'd1 : 32'd0);
                    push_exp("d_fwd0", 32'h0BAD);
                end
                default: begin
                    drive_idle();
                    m_wd = 32'h55AA; w_wd = 32'h55AA; e_op = {32'h0, 32'h0BAD};
                    push_exp("e_fwd0", 32'h55AA);
                end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL load_use %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_long_latency();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc == 0) begin
                issue(5'd11, 1'b1, 2'd3);
                push_exp("stall", 0);
            end else begin
                consume(5'd11, 2'd0);
                d_rd = {32'h0, 32'hC0DE_0011};
                push_exp("stall", (cyc <= 3) ? 32'd1 : 32'd0);
                if (cyc == 4) push_exp("d_fwd0", 32'hC0DE_0011);
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL long_latency %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_bubble_no_stall();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 3; cyc++) begin
            case (cyc)
                0: issue(5'd12, 1'b1, 2'd3);
                1: begin consume(5'd12, 2'd0); d_valid = 1'b0; push_exp("stall", 0); end
                default: begin consume(5'd12, 2'd0); push_exp("stall", 1); end
            endcase
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL bubble %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back_priority();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 7; cyc++) begin
            if (cyc < 3) begin
                issue(5'd10, 1'b1, 2'd0);
                push_exp("stall", 0);
            end else begin
                consume(5'd10, 2'd0);
                e_wd = 32'hE0; m_wd = 32'hA0; w_wd = 32'hB0;
                d_rd = {32'h0, 32'hD0}; e_op = {32'h0, 32'hE1}; m_op = {32'h0, 32'hF1};
                case (cyc)
                    3: begin push_exp("stall", 0); push_exp("d_fwd0", 32'hE0); end
                    4: begin push_exp("d_fwd0", 32'hA0); push_exp("e_fwd0", 32'hA0); end
                    5: begin
                        push_exp("d_fwd0", 32'hB0); push_exp("e_fwd0", 32'hB0);
                        push_exp("m_fwd0", 32'hB0);
                    end
                    default: begin
                        push_exp("d_fwd0", 32'hD0); push_exp("e_fwd0", 32'hE1);
                        push_exp("m_fwd0", 32'hF1);
                    end
                endcase
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL priority %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reg_zero();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 2; cyc++) begin
            if (cyc == 0) begin
                issue(5'd0, 1'b1, 2'd3);
            end else begin
                consume(5'd0, 2'd0);
                e_wd = 32'hFFFF_0000; d_rd = {32'h0, 32'h1234_5678};
                push_exp("stall", 0);
                push_exp("d_fwd0", 32'h1234_5678);
            end
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL reg_zero %s: got %h expected %h", e.name, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stall();
        issue(5'd13, 1'b1, 2'd3);
        next_cycle();
        consume(5'd13, 2'd0);
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_stall_before: got %b expected 1", stall);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_stall_in_reset: got %b expected 0", stall);
        end
        #1;
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (stall !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_stall_after_reset: got %b expected 0", stall);
        end
        next_cycle();
    endtask

    task automatic test_mult_div();
        exp_t e;
        logic [31:0] act;
        for (int cyc = 0; cyc < 13; cyc++) begin
            drive_idle();
            d_valid = 1'b1; d_md_use = 1'b1;
            if (cyc == 0) begin
                d_md_start = 1'b1; d_md_div = 1'b1;
            end
`ifdef HAZARD_MD_EN
            push_exp("stall", (cyc >= 1 && cyc <= 11) ? 32'd1 : 32'd0);
            push_exp("md_busy", (cyc >= 2 && cyc <= 11) ? 32'd1 : 32'd0);
`else
            push_exp("stall", 0);
            push_exp("md_busy", 0);
`endif
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); act = observe(e.name); tests_run++;
                if (act !== e.val) begin
                    tests_failed++;
                    $display("[TB] FAIL mult_div %s cycle %0d: got %h expected %h",
                             e.name, cyc, act, e.val);
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b0;
        drive_idle();
        d_rd = '0; e_op = '0; m_op = '0;
        e_wd = '0; m_wd = '0; w_wd = '0;
        next_cycle();
        test_reset();
        reset = 1'b1;
        flush();
        test_alu_chain();
        flush();
        test_load_use();
        flush();
        test_long_latency();
        flush();
        test_bubble_no_stall();
        flush();
        test_back_to_back_priority();
        flush();
        test_reg_zero();
        flush();
        test_reset_mid_stall();
        flush();
        test_mult_div();
        flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
